mem_stage_wait: RTL and testbench

Parametrised successor to the single-cycle MEM pass-through stage. It contains the data memory and models a configurable number of wait states, so a load or store takes several cycles. While an access is in flight it stalls the upstream pipeline and inserts bubbles into MEM/WB. It sits between the EXE/MEM and MEM/WB pipeline registers of the ARM core.

---
 rtl/mem_pkg.sv | 10 +
 rtl/data_memory.sv | 16 +
 rtl/mem_stage_wait.sv | 70 +++++++
 tb/tb_mem_stage_wait.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding, default base address and index-width helper for the wait-state MEM stage
package mem_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int BASE_ADDR_DEF = 1024;
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/data_memory.sv
// data_memory: word array with synchronous write and asynchronous read
module data_memory import mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[idx] <= wdata;
  assign rdata = r_mem[idx];
endmodule

// File: rtl/mem_stage_wait.sv
// mem_stage_wait: MEM stage with data memory and WAIT_CYCLES busy cycles per access, stalling upstream meanwhile
module mem_stage_wait import mem_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC_in,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [3:0]        dest,
  output logic [DATA_W-1:0] PC,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [3:0]        dest_out,
  output logic [DATA_W-1:0] data_mem_out,
  output logic              stall,
  output logic              addr_err
);
  localparam int AW = addr_w(DEPTH);
  localparam int CW = addr_w(WAIT_CYCLES);
  logic [1:0]        r_state, w_next;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [DATA_W-1:0] w_off, w_rdata;
  logic [AW-1:0]     w_idx;
  logic              w_req, w_in_range, w_fin, w_we;
  assign w_req      = mem_r_en | mem_w_en;
  assign w_off      = alu_res - DATA_W'(BASE_ADDR);
  assign w_idx      = w_off[AW+1:2];
  assign w_in_range = (alu_res >= DATA_W'(BASE_ADDR)) && ((w_off >> 2) < DATA_W'(DEPTH));
  assign w_fin      = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_we       = w_fin & mem_w_en & w_in_range;
  assign w_next = (r_state == S_IDLE) ? (w_req ? S_BUSY : S_IDLE) :
                  (r_state == S_BUSY) ? (w_fin ? S_DONE : S_BUSY) : S_IDLE;
  assign w_cnt  = (r_state == S_IDLE && w_req) ? CW'(WAIT_CYCLES - 1) :
                  (r_state == S_BUSY && !w_fin) ? r_cnt - CW'(1) : r_cnt;
  // reset drops stall without waiting for a clock edge
  assign stall        = ~rst & ((r_state == S_IDLE) ? w_req : (r_state == S_BUSY));
  assign wb_en_out    = wb_en & ~stall;
  assign mem_r_en_out = mem_r_en & ~stall;
  assign PC           = PC_in;
  assign alu_res_out  = alu_res;
  assign dest_out     = dest;
  data_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .idx   (w_idx),
    .wdata (val_rm),
    .rdata (w_rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      data_mem_out <= '0;
      addr_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_fin) addr_err <= ~w_in_range;
      else if (r_state == S_DONE) addr_err <= 1'b0;
      if (w_fin && mem_r_en && !mem_w_en) data_mem_out <= w_in_range ? w_rdata : '0;
    end
endmodule

// File: tb/tb_mem_stage_wait.sv
// tb_mem_stage_wait: scoreboard bench for two stage instances (WAIT_CYCLES 2 and 1)
module tb_mem_stage_wait;
  typedef struct {logic [31:0] data; logic err;} exp_t;
  logic        clk = 1'b0;
  logic        rst [2], rd [2], wr [2], wbe [2];
  logic        stall [2], wb_o [2], rd_o [2], err [2];
  logic [31:0] pc [2], addr [2], wd [2], pc_o [2], alu_o [2], dout [2];
  logic [3:0]  dst [2], dst_o [2];
  logic [31:0] mdl [2][64];
  logic [31:0] edout [2];
  exp_t        sbq [$];
  int          n_chk = 0, n_fail = 0, cyc = 0, c0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  mem_stage_wait #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .PC_in(pc[0]), .wb_en(wbe[0]), .mem_r_en(rd[0]), .mem_w_en(wr[0]),
    .alu_res(addr[0]), .val_rm(wd[0]), .dest(dst[0]), .PC(pc_o[0]), .wb_en_out(wb_o[0]),
    .mem_r_en_out(rd_o[0]), .alu_res_out(alu_o[0]), .dest_out(dst_o[0]), .data_mem_out(dout[0]),
    .stall(stall[0]), .addr_err(err[0])
  );
  mem_stage_wait #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .PC_in(pc[1]), .wb_en(wbe[1]), .mem_r_en(rd[1]), .mem_w_en(wr[1]),
    .alu_res(addr[1]), .val_rm(wd[1]), .dest(dst[1]), .PC(pc_o[1]), .wb_en_out(wb_o[1]),
    .mem_r_en_out(rd_o[1]), .alu_res_out(alu_o[1]), .dest_out(dst_o[1]), .data_mem_out(dout[1]),
    .stall(stall[1]), .addr_err(err[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] v, input int waits);
    exp_t        e;
    int          n;
    logic [31:0] off;
    bit          inr;
    off = a - 32'd1024;
    inr = (a >= 32'd1024) && ((off >> 2) < 32'd64);
    if (w) begin
      if (inr) mdl[d][off[7:2]] = v;
    end else if (r) edout[d] = inr ? mdl[d][off[7:2]] : 32'h0;
    e.data = edout[d];
    e.err  = !inr;
    sbq.push_back(e);
    rd[d] = r; wr[d] = w; wbe[d] = r; addr[d] = a; wd[d] = v; pc[d] = a + 7; dst[d] = a[5:2];
    n = 0;
    @(negedge clk);
    while (stall[d] && n < 20) begin
      chk("gate_wb", {31'b0, wb_o[d] | rd_o[d]}, 32'd0);
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, waits + 1);
    e = sbq.pop_front();
    chk("dout", dout[d], e.data);
    chk("addr_err", {31'b0, err[d]}, {31'b0, e.err});
    chk("rd_o_done", {31'b0, rd_o[d]}, {31'b0, r});
    chk("wb_o_done", {31'b0, wb_o[d]}, {31'b0, r});
    @(posedge clk);
    #1;
    chk("err_clr", {31'b0, err[d]}, 32'd0);
    rd[d] = 0; wr[d] = 0; wbe[d] = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; rd[d] = 0; wr[d] = 0; wbe[d] = 0;
      pc[d] = 0; addr[d] = 0; wd[d] = 0; dst[d] = 0; edout[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", {31'b0, stall[d]}, 32'd0);
      chk("rst_dout", dout[d], 32'd0);
      chk("rst_err", {31'b0, err[d]}, 32'd0);
    end
    @(negedge clk);
    rst[0] = 0; rst[1] = 0;
    @(posedge clk);
    #1;
    access(0, 0, 1, 32'd1028, 32'hDEADBEEF, 2);
    access(0, 1, 0, 32'd1028, 32'h0, 2);
    wbe[0] = 1; addr[0] = 32'h55; pc[0] = 32'h100; dst[0] = 4'd9;
    #1;
    chk("nm_stall", {31'b0, stall[0]}, 32'd0);
    chk("nm_wb", {31'b0, wb_o[0]}, 32'd1);
    chk("nm_alu", alu_o[0], 32'h55);
    chk("nm_pc", pc_o[0], 32'h100);
    chk("nm_dest", {28'b0, dst_o[0]}, 32'd9);
    chk("nm_dout", dout[0], edout[0]);
    @(posedge clk);
    #1;
    wbe[0] = 0;
    access(0, 0, 1, 32'd1024, 32'hA5A5A5A5, 2);
    access(0, 1, 0, 32'd1020, 32'h0, 2);
    access(0, 0, 1, 32'd1280, 32'h00000BAD, 2);
    access(0, 1, 0, 32'd1024, 32'h0, 2);
    access(0, 1, 1, 32'd1032, 32'h12345678, 2);
    access(0, 1, 0, 32'd1032, 32'h0, 2);
    access(0, 0, 1, 32'd1040, 32'h11111111, 2);
    wr[0] = 1; addr[0] = 32'd1040; wd[0] = 32'h22222222;
    @(negedge clk);
    @(negedge clk);
    chk("busy_stall", {31'b0, stall[0]}, 32'd1);
    #2;
    rst[0] = 1;
    #1;
    chk("midrst_stall", {31'b0, stall[0]}, 32'd0);
    chk("midrst_dout", dout[0], 32'd0);
    chk("midrst_err", {31'b0, err[0]}, 32'd0);
    edout[0] = 0;
    wr[0] = 0;
    @(negedge clk);
    rst[0] = 0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {31'b0, stall[0]}, 32'd0);
    access(0, 1, 0, 32'd1040, 32'h0, 2);
    access(1, 0, 1, 32'd1024, 32'hCAFE0001, 1);
    access(1, 0, 1, 32'd1028, 32'hCAFE0002, 1);
    c0 = cyc;
    access(1, 1, 0, 32'd1024, 32'h0, 1);
    access(1, 1, 0, 32'd1028, 32'h0, 1);
    chk("b2b_cycles", cyc - c0, 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
